// File: rtl/mc_maindec.sv
// Multicycle main control decoder: Moore FSM sequencing fetch, decode,
// memory, ALU and writeback steps, with memready stretching memory states.
module mc_maindec (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] aluop,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0] r_state;
  logic [3:0] w_st;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH:   if (memready) r_state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW,
            OP_SW:   r_state <= MEMADR;
            OP_RTYP: r_state <= RTYPEEX;
            OP_BEQ:  r_state <= BEQEX;
            OP_ADDI: r_state <= ADDIEX;
            OP_J:    r_state <= JEX;
            default: r_state <= FETCH;
          endcase
        end
        MEMADR: begin
          case (op)
            OP_LW:   r_state <= MEMRD;
            OP_SW:   r_state <= MEMWR;
            default: r_state <= FETCH;
          endcase
        end
        MEMRD:   if (memready) r_state <= MEMWB;
        MEMWR:   if (memready) r_state <= FETCH;
        RTYPEEX: r_state <= RTYPEWB;
        ADDIEX:  r_state <= ADDIWB;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Reset shows FETCH outputs immediately, before the edge lands
  assign w_st    = reset ? FETCH : r_state;
  assign state_o = w_st;

  always_comb begin
    memwrite = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    aluop    = 2'b00;
    unique case (w_st)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = memready;
        pcwrite = memready;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR,
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mc_maindec.md
MC_MAINDEC -- requirements
Module: mc_maindec

Interface
REQ-001 The module SHALL use one clock; reset is synchronous and active-high.
REQ-002 The ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op  in  6  instruction opcode from the instruction register
- memready  in  1  memory completes the current access this cycle
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- pcwrite  out  1  unconditional PC load
- branch  out  1  conditional PC load (datapath ANDs this with zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = regB, 01 = const 4, 10 = sign-extended immediate, 11 = immediate shifted left 2
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALU out register, 10 = jump target
- regwrite  out  1  register file write enable
- regdst  out  1  destination select: 0 = rt, 1 = rd
- memtoreg  out  1  writeback select: 0 = ALU out, 1 = memory data
- aluop  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = use funct
- state_o  out  4  current state, for debug only

Function
REQ-003 Control SHALL be a Moore FSM; all outputs except memory-gated strobes decode from state only.
REQ-004 State encoding SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11; codes 12–15 SHALL go to FETCH on the next edge.
REQ-005 Opcodes SHALL be: lw=100011, sw=101011, R-type=000000, beq=000100, addi=001000, j=000010.
REQ-006 Outputs not listed for a state SHALL be 0.
REQ-007 FETCH outputs SHALL be: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=memready.
REQ-008 DECODE outputs SHALL be: alusrca=0, alusrcb=11, aluop=00.
REQ-009 MEMADR and ADDIEX outputs SHALL be: alusrca=1, alusrcb=10, aluop=00.
REQ-010 MEMRD outputs SHALL be iord=1.
REQ-011 MEMWB outputs SHALL be regdst=0, memtoreg=1, regwrite=1.
REQ-012 MEMWR outputs SHALL be iord=1, memwrite=1.
REQ-013 RTYPEEX outputs SHALL be alusrca=1, alusrcb=00, aluop=10.
REQ-014 RTYPEWB outputs SHALL be regdst=1, memtoreg=0, regwrite=1.
REQ-015 BEQEX outputs SHALL be alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
REQ-016 ADDIWB outputs SHALL be regdst=0, memtoreg=0, regwrite=1.
REQ-017 JEX outputs SHALL be pcsrc=10, pcwrite=1.
REQ-018 Transitions SHALL be:
- FETCH->DECODE if memready, else stay in FETCH.
- DECODE->MEMADR on lw/sw, RTYPEEX on R-type, BEQEX on beq, ADDIEX on addi, JEX on j; any other opcode -> FETCH.
- MEMADR->MEMRD on lw, MEMWR on sw.
- MEMRD->MEMWB if memready, else stay.
- MEMWR->FETCH if memready, else stay; memwrite stays high while waiting.
- RTYPEEX->RTYPEWB, ADDIEX->ADDIWB.
- MEMWB, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH.
REQ-019 op SHALL be sampled only in DECODE and MEMADR; op changes in other states SHALL have no effect.
REQ-020 Instruction cycle counts with memready held high SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-021 Each cycle memready is low in FETCH, MEMRD or MEMWR SHALL add exactly one cycle, with outputs held constant.

Reset
REQ-022 reset high at a clock edge SHALL force FETCH on that edge from any state, including mid-wait.
REQ-023 reset SHALL take priority over memready and op.
REQ-024 While in reset, outputs SHALL be FETCH values: alusrcb=01, all other multi-bit outputs 00, irwrite=pcwrite=memready, all other single-bit outputs 0, state_o=0.

Verification
REQ-025 Reset then lw (op=100011), memready=1 -> state_o sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-026 R-type (op=000000) -> RTYPEEX shows aluop=10, alusrca=1; RTYPEWB shows regdst=1, regwrite=1; back to FETCH after 4 cycles.
REQ-027 beq (op=000100) -> BEQEX shows aluop=01, branch=1, pcsrc=01, pcwrite=0; j (op=000010) -> JEX shows pcsrc=10, pcwrite=1.
REQ-028 sw with memready low for 3 cycles in MEMWR -> memwrite held high for 4 cycles, then FETCH; FETCH with memready low -> irwrite=pcwrite=0, state stays 0.
REQ-029 Undefined op 111111 in DECODE -> FETCH next cycle, with no regwrite/memwrite asserted.
REQ-030 reset asserted during MEMRD wait -> state_o=0 on the next edge; forcing state to 13 -> FETCH on the next edge.
